// File: rtl/regfile_sb.sv
// regfile_sb: parametrised integer register file for the RV32I decode stage.
// Provides NREAD combinational read ports, a per-register pending-write
// scoreboard, and a sequenced bulk-clear engine (IDLE -> CLEAR -> IDLE).
// Register 0 is hardwired to zero and is never pending.
// Optional feature: define REGFILE_BYPASS_EN for same-cycle write-to-read
// bypass (active only while the clear engine is idle).
module regfile_sb #(
    parameter  int XLEN  = 32,
    parameter  int NREGS = 32,
    parameter  int NREAD = 2,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [XLEN-1:0]       wr_data,
    input  logic [NREAD*AW-1:0]   rd_addr,
    output logic [XLEN*NREAD-1:0] rd_data,
    output logic [NREAD-1:0]      rd_pending,
    input  logic                  sb_set,
    input  logic [AW-1:0]         sb_addr,
    input  logic                  clear_req,
    output logic                  clear_busy,
    output logic                  clear_done
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t                state_r;
    logic [AW-1:0]         idx_r;
    logic                  clear_busy_r;
    logic                  clear_done_r;
    logic [XLEN-1:0]       regs_r [NREGS];
    logic [NREGS-1:0]      pend_r;

    logic                  wr_ok_s;
    logic                  sb_ok_s;
    logic [XLEN*NREAD-1:0] rd_data_s;
    logic [NREAD-1:0]      rd_pending_s;

    // Writeback and issue are only honoured while idle and never for x0;
    // during a clear they are dropped outright.
    assign wr_ok_s = (state_r == ST_IDLE) && wr_en && (wr_addr != '0);
    assign sb_ok_s = (state_r == ST_IDLE) && sb_set && (sb_addr != '0);

    assign rd_data    = rd_data_s;
    assign rd_pending = rd_pending_s;
    assign clear_busy = clear_busy_r;
    assign clear_done = clear_done_r;

    // Clear sequencer: walks idx from 1 to NREGS-1, then pulses done for one cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= ST_IDLE;
            idx_r        <= '0;
            clear_busy_r <= 1'b0;
            clear_done_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    clear_done_r <= 1'b0;
                    if (clear_req) begin
                        state_r      <= ST_CLEAR;
                        idx_r        <= AW'(1);
                        clear_busy_r <= 1'b1;
                    end else begin
                        state_r      <= ST_IDLE;
                        idx_r        <= idx_r;
                        clear_busy_r <= 1'b0;
                    end
                end
                ST_CLEAR: begin
                    if (idx_r == AW'(NREGS - 1)) begin
                        state_r      <= ST_IDLE;
                        idx_r        <= '0;
                        clear_busy_r <= 1'b0;
                        clear_done_r <= 1'b1;
                    end else begin
                        state_r      <= ST_CLEAR;
                        idx_r        <= idx_r + AW'(1);
                        clear_busy_r <= 1'b1;
                        clear_done_r <= 1'b0;
                    end
                end
                default: begin
                    state_r      <= ST_IDLE;
                    idx_r        <= '0;
                    clear_busy_r <= 1'b0;
                    clear_done_r <= 1'b0;
                end
            endcase
        end
    end

    // Register storage: the clear engine owns the write port while busy.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int r = 0; r < NREGS; r++) begin
                regs_r[r] <= '0;
            end
        end else if (state_r == ST_CLEAR) begin
            regs_r[idx_r] <= '0;
        end else if (wr_ok_s) begin
            regs_r[wr_addr] <= wr_data;
        end
    end

    // Pending scoreboard: writeback clears, issue sets; set is applied last so it wins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_r <= '0;
        end else if ((state_r == ST_IDLE) && clear_req) begin
            pend_r <= '0;
        end else begin
            if (wr_ok_s) begin
                pend_r[wr_addr] <= 1'b0;
            end
            if (sb_ok_s) begin
                pend_r[sb_addr] <= 1'b1;
            end
        end
    end

    // Combinational read ports, each independent; x0 always reads zero and not pending.
    always_comb begin
        rd_data_s    = '0;
        rd_pending_s = '0;
        for (int i = 0; i < NREAD; i++) begin
            if (rd_addr[i*AW +: AW] == '0) begin
                rd_data_s[i*XLEN +: XLEN] = '0;
                rd_pending_s[i]           = 1'b0;
            end else begin
`ifdef REGFILE_BYPASS_EN
                if (wr_ok_s && (wr_addr == rd_addr[i*AW +: AW])) begin
                    rd_data_s[i*XLEN +: XLEN] = wr_data;
                    rd_pending_s[i]           = 1'b0;
                end else begin
                    rd_data_s[i*XLEN +: XLEN] = regs_r[rd_addr[i*AW +: AW]];
                    rd_pending_s[i]           = (state_r == ST_IDLE) && pend_r[rd_addr[i*AW +: AW]];
                end
`else
                rd_data_s[i*XLEN +: XLEN] = regs_r[rd_addr[i*AW +: AW]];
                rd_pending_s[i]           = (state_r == ST_IDLE) && pend_r[rd_addr[i*AW +: AW]];
`endif
            end
        end
    end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised integer register file for the pipelined RV32I core, replacing the fixed 2-read/1-write file in the decode stage. It adds a configurable number of read ports, a per-register pending-write scoreboard for hazard detection, optional same-cycle write-to-read bypass, and a sequenced bulk-clear engine. The decode stage reads operands and scoreboard status; writeback drives the write port.

## Interface
- XLEN, 32: data width in bits.
- NREGS, 32: number of architectural registers; power of two, at least 4. Register 0 is hardwired zero.
- NREAD, 2: number of read ports, at least 1.
- AW (localparam), $clog2(NREGS): register address width.

- Clk  in  1  single clock; all state updates on the rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- Wr_en  in  1  writeback valid.
- Wr_addr  in  AW  writeback destination.
- Wr_data  in  XLEN  writeback data.
- Rd_addr  in  NREAD*AW  read addresses; port i uses bits [i*AW +: AW].
- Rd_data  out  XLEN*NREAD  read data; port i uses bits [i*XLEN +: XLEN].
- Rd_pending  out  NREAD  port i source register has an outstanding write.
- Sb_set  in  1  issue marks a destination as pending.
- Sb_addr  in  AW  destination being marked.
- Clear_req  in  1  start a bulk clear of registers 1..NREGS-1.
- Clear_busy  out  1  bulk clear in progress.
- Clear_done  out  1  one-cycle pulse when the clear completes.

## Operation
- Reset (Reset_n low, asynchronous): all registers read 0, all pending bits are 0, the FSM is IDLE, Clear_busy=0, Clear_done=0. Rd_data and Rd_pending are 0 for every address.
- Register 0:
  - Always reads 0.
  - Writes to it are ignored.
  - It is never pending; Sb_set with Sb_addr=0 is ignored.
- Write: Wr_en=1 and Wr_addr≠0 loads Wr_data at the edge and clears pend[Wr_addr].
- Read is combinational: Rd_data[i] = reg[Rd_addr[i]] and Rd_pending[i] = pend[Rd_addr[i]]. All ports are independent; any ports may alias the same address.
- Scoreboard:
  - Sb_set sets pend[Sb_addr].
  - Setting a bit that is already set leaves it set; there is no counting.
  - If Sb_set and Wr_en target the same address in the same cycle, the set wins and the bit is 1 after the edge.
  - A write to an address that is not pending is legal and leaves the bit 0.
- FSM states:
  - IDLE to CLEAR on Clear_req=1. On this transition all pending bits clear and the index loads 1.
  - In CLEAR, reg[idx] is written 0 each cycle and idx increments.
  - CLEAR to IDLE after the cycle that clears NREGS-1. Clear_done=1 for exactly that one following cycle.
  - Clear_req while in CLEAR is ignored.
- During CLEAR:
  - Wr_en and Sb_set are ignored (dropped, not queued).
  - Rd_pending is all 0.
  - Reads return current contents, so the file may be partially cleared.
  - Bypass is disabled.
- Reset asserted mid-clear aborts the clear immediately: FSM to IDLE, all state zeroed, no Clear_done.

## Timing
- Write latency: visible to reads in the cycle after the write edge. With the bypass option enabled it is also visible in the same cycle.
- Scoreboard update: visible in the cycle after the edge.
- Clear sequence with Clear_req sampled at edge T0:
  - Clear_busy=1 during cycles T0+1 through T0+NREGS-1.
  - Register k reads 0 from edge T0+k onward.
  - Clear_done=1 during cycle T0+NREGS; Clear_busy=0 in that cycle.
  - A new Clear_req is accepted in the Clear_done cycle.
- No combinational path from Clear_req to any output.

## Configuration
- REGFILE_BYPASS_EN defined, while IDLE, for a read address equal to Wr_addr with Wr_en=1 and address ≠0:
  - Rd_data returns Wr_data in the same cycle.
  - Rd_pending returns 0 in the same cycle.
  - If Sb_set targets the same address in that cycle, Rd_pending still returns 0 in that cycle; the bit is 1 from the next cycle.
- REGFILE_BYPASS_EN undefined:
  - Reads return the pre-edge register value.
  - Rd_pending reflects the pre-edge bit.
  - The pipeline must stall one extra cycle.

## Test plan
- Reset then read: hold Reset_n low, read addresses 0, 5 and 31 on all ports -> Rd_data=0 and Rd_pending=0. Write 0xDEADBEEF to x0 -> x0 still reads 0.
- Write/read across ports (NREAD=3): write x7=0x12345678, then read x7 on all three ports the next cycle -> all ports show 0x12345678.
- Same-cycle bypass: Wr_en with x9=0xA5A5A5A5 while port 1 reads x9 (old value 0x1) -> 0xA5A5A5A5 with REGFILE_BYPASS_EN, 0x1 without.
- Scoreboard:
  - Sb_set x3, then port 0 reads x3 -> Rd_pending[0]=1.
  - Write x3 in the same cycle as Sb_set x3 -> pend[x3] stays 1.
  - A later write to x3 -> pend[x3]=0 the following cycle.
- Bulk clear: fill x1..x31 with nonzero values, pulse Clear_req. Drive Wr_en x4=0xFF on the second busy cycle ->
  - Clear_busy high for 31 cycles.
  - The x4 write is dropped.
  - All registers read 0.
  - Clear_done is a single-cycle pulse.
- Reset mid-clear: pulse Clear_req, then drop Reset_n at cycle 10 -> Clear_busy=0 immediately, no Clear_done, all registers 0, and the FSM accepts a new Clear_req after release.
